// File: rtl/note_mixer_pwm_pkg.sv
// Shared types and constants for the note mixer / PWM audio block.
//   env_state_t : per-voice envelope FSM states
//   Def*        : default parameter values
//   EnvMax      : peak envelope level for the default level width
package note_mixer_pwm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAttack,
    StSustain,
    StRelease
  } env_state_t;

  localparam int unsigned DefNumVoices    = 8;
  localparam int unsigned DefEnvW         = 4;
  localparam int unsigned DefEnvStepCycles = 65536;
  localparam int unsigned DefPwmW         = 7;

  // Peak level representable in a w-bit envelope.
  function automatic int unsigned env_max(int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned EnvMax = env_max(DefEnvW);

endpackage

// File: rtl/note_mixer_pwm_if.sv
// Signal bundle between the tone/key front end and the mixer.
//   note_en       : conditioned key enables, one bit per voice
//   tone          : square-wave tone bits, one per voice
//   pwm_out       : single-bit PWM audio output
//   sample        : currently latched mixed sample
//   active_voices : number of voices not idle
// master drives keys/tones, slave (the mixer) drives the audio side.
interface note_mixer_pwm_if #(
  parameter int unsigned NumVoices = 8,
  parameter int unsigned PwmW      = 7
);
  logic [NumVoices-1:0] note_en;
  logic [NumVoices-1:0] tone;
  logic                 pwm_out;
  logic [PwmW-1:0]      sample;
  logic [3:0]           active_voices;

  modport master (
    output note_en, tone,
    input  pwm_out, sample, active_voices
  );

  modport slave (
    input  note_en, tone,
    output pwm_out, sample, active_voices
  );
endinterface

// File: rtl/note_mixer_pwm_voice_envelope.sv
// Attack/sustain/release envelope for one voice.
//   clk, reset_n : clock, synchronous active-low reset
//   tick         : one-cycle envelope step strobe
//   note_en      : key held for this voice
//   level        : current envelope level
//   active       : voice is not idle
module note_mixer_pwm_voice_envelope
  import note_mixer_pwm_pkg::*;
#(
  parameter int unsigned EnvW = DefEnvW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tick,
  input  logic            note_en,
  output logic [EnvW-1:0] level,
  output logic            active
);

  localparam logic [EnvW-1:0] LevelMax = EnvW'(env_max(EnvW));

  env_state_t      state_q, state_d;
  logic [EnvW-1:0] level_q, level_d;

  // Key changes win over a coincident tick: the level is not stepped that cycle.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      StIdle: begin
        level_d = '0;
        if (note_en) state_d = StAttack;
      end
      StAttack: begin
        if (!note_en) begin
          state_d = StRelease;
        end else if (tick) begin
          if (level_q != LevelMax) level_d = level_q + 1'b1;
          if (level_d == LevelMax) state_d = StSustain;
        end
      end
      StSustain: begin
        level_d = LevelMax;
        if (!note_en) state_d = StRelease;
      end
      StRelease: begin
        // Re-press resumes the attack from the current level.
        if (note_en) begin
          state_d = StAttack;
        end else if (tick) begin
          if (level_q != '0) level_d = level_q - 1'b1;
          if (level_d == '0) state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        level_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  assign level  = level_q;
  assign active = (state_q != StIdle);

endmodule

// File: rtl/note_mixer_pwm.sv
// Per-voice envelopes, voice mixer and PWM audio output.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : note_en/tone in; pwm_out/sample/active_voices out
module note_mixer_pwm
  import note_mixer_pwm_pkg::*;
#(
  parameter int unsigned NumVoices     = DefNumVoices,
  parameter int unsigned EnvW          = DefEnvW,
  parameter int unsigned EnvStepCycles = DefEnvStepCycles,
  parameter int unsigned PwmW          = DefPwmW
) (
  input logic              clk,
  input logic              reset_n,
  note_mixer_pwm_if.slave  bus
);

  localparam int unsigned PrescW    = (EnvStepCycles > 1) ? $clog2(EnvStepCycles) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(EnvStepCycles - 1);
  localparam logic [PwmW-1:0]   CntLast   = '1;
  localparam int unsigned SampleMax = (32'd1 << PwmW) - 32'd1;

  logic [PrescW-1:0]   presc_q, presc_d;
  logic [PwmW-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [PwmW-1:0]     sample_q, sample_d;
  logic                pwm_out_q, pwm_out_d;
  logic [3:0]          active_voices_q, active_voices_d;
  logic                tick;
  logic [EnvW-1:0]     level [NumVoices];
  logic [NumVoices-1:0] active;
  logic [31:0]         mix_sum;
  logic [PwmW-1:0]     mix_sat;

  assign tick = (presc_q == PrescLast);

  for (genvar g = 0; g < NumVoices; g++) begin : g_voice
    note_mixer_pwm_voice_envelope #(
      .EnvW (EnvW)
    ) u_env (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .note_en (bus.note_en[g]),
      .level   (level[g]),
      .active  (active[g])
    );
  end

  // Wide accumulator so non-default parameters saturate instead of wrapping.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NumVoices; i++) begin
      if (bus.tone[i]) mix_sum = mix_sum + 32'(level[i]);
    end
    mix_sat = (mix_sum > SampleMax) ? PwmW'(SampleMax) : mix_sum[PwmW-1:0];
  end

  always_comb begin
    presc_d         = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d       = pwm_cnt_q + 1'b1;
    sample_d        = (pwm_cnt_q == CntLast) ? mix_sat : sample_q;
    pwm_out_d       = (pwm_cnt_q < sample_q);
    active_voices_d = '0;
    for (int i = 0; i < NumVoices; i++) begin
      active_voices_d = active_voices_d + {3'b000, active[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q         <= '0;
      pwm_cnt_q       <= '0;
      sample_q        <= '0;
      pwm_out_q       <= 1'b0;
      active_voices_q <= '0;
    end else begin
      presc_q         <= presc_d;
      pwm_cnt_q       <= pwm_cnt_d;
      sample_q        <= sample_d;
      pwm_out_q       <= pwm_out_d;
      active_voices_q <= active_voices_d;
    end
  end

  assign bus.pwm_out       = pwm_out_q;
  assign bus.sample        = sample_q;
  assign bus.active_voices = active_voices_q;

endmodule

// File: doc/note_mixer_pwm.md
Name: note_mixer_pwm

Overview:
- Sits directly downstream of the per-note tone generators in the FPGA piano.
- Consumes the 8 conditioned note enables and the 8 square-wave tone bits.
- Applies a per-voice attack/sustain/release amplitude envelope, sums the voices into one sample, and drives a single-bit PWM audio output to the speaker pin.

Parameters:
- NUM_VOICES, 8: number of note voices.
- ENV_W, 4: envelope level width; maximum level ENV_MAX = 2^ENV_W-1 = 15.
- ENV_STEP_CYCLES, 65536: clk cycles per envelope step (one tick).
- PWM_W, 7: PWM counter/sample width; PWM period is 2^PWM_W = 128 clk.

Ports:
- clk  in  1  system clock; the single clock for the block.
- reset_n  in  1  synchronous, active-low reset.
- note_en  in  NUM_VOICES  conditioned key enables; bit i = voice i (C..C2).
- tone  in  NUM_VOICES  square-wave tone bits from the note generators.
- pwm_out  out  1  PWM audio output.
- sample  out  PWM_W  currently latched mixed sample.
- active_voices  out  4  registered count of voices not in IDLE.

Behaviour:
- Reset (reset_n=0 at a clk edge) clears everything. This applies mid-operation too, with no exceptions.
  - All voice states go to IDLE and all levels go to 0.
  - The prescaler and pwm_cnt go to 0.
  - sample, pwm_out and active_voices go to 0.
- Prescaler counts 0..ENV_STEP_CYCLES-1 and wraps. A tick is asserted for the one cycle in which it equals ENV_STEP_CYCLES-1.
- Per-voice FSM, evaluated every clk:
  - IDLE: level=0. note_en=1 -> ATTACK.
  - ATTACK: on tick, level+1; if the new level equals ENV_MAX, go to SUSTAIN on the same edge. note_en=0 -> RELEASE.
  - SUSTAIN: level held at ENV_MAX. note_en=0 -> RELEASE.
  - RELEASE: on tick, level-1; if the new level is 0, go to IDLE on the same edge. note_en=1 -> ATTACK, resuming from the current level (no restart from 0).
- Simultaneous events:
  - An enable-driven transition in the same cycle as a tick takes precedence, and the level is not stepped that cycle.
  - Level never wraps: it is clamped at 0 and ENV_MAX.
- Mix: mix = sum over i of (tone[i] ? level[i] : 0).
  - Computed at width PWM_W+1, then saturated to 2^PWM_W-1.
  - With default parameters the maximum is 120, so no saturation occurs.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_W-1.
  - In the cycle pwm_cnt = 2^PWM_W-1, sample <= mix.
  - pwm_out is registered: pwm_out <= (pwm_cnt < sample).
  - sample=0 gives pwm_out constantly 0; sample=S gives exactly S high cycles per 128-cycle period.
  - Latency: a latched sample is reflected in pwm_out starting 1 clk after pwm_cnt returns to 0.
- active_voices is registered and updated every clk from the voice states (1-cycle lag).
- tone is sampled combinationally into mix. The tone generators share clk, so no synchroniser is needed.

Decomposition:
- Shared package holds:
  - env_state_t enum: IDLE, ATTACK, SUSTAIN, RELEASE.
  - ENV_MAX constant.
  - Default parameter constants.
- Sub-module voice_envelope is instantiated NUM_VOICES times.
  - Ports: clk, reset_n, tick, note_en, level[ENV_W-1:0], active.
  - It contains the FSM and level register.
- The top level holds the prescaler, mixer adder tree, sample latch, PWM counter and active-voice popcount.

Test Plan (ENV_STEP_CYCLES=4 for sim):
- Reset: drive reset_n=0 for 3 clk mid-sustain with all voices on -> on the following edges pwm_out=0, sample=0, active_voices=0; after release of reset with note_en=0, all stay 0.
- Single attack: hold note_en[0]=1 and tone[0]=1 -> level rises by 1 every 4 clk and reaches 15 after 15 ticks (state SUSTAIN); next latched sample=15; pwm_out is high exactly 15 of 128 clk per period; active_voices=1.
- Full chord: all 8 voices sustained with tone=8'hFF -> sample=120; pwm_out high 120/128. Then tone=8'h0F -> next latched sample=60.
- Release: drop note_en[0] at level 15 -> level falls to 0 in 15 ticks; the voice goes IDLE; active_voices goes 1->0 one clk after the IDLE transition.
- Re-press during release at level 7 -> ATTACK resumes from 7 and reaches 15 after 8 ticks (not 15).
- Tick/enable collision: deassert note_en in the exact tick cycle during ATTACK at level 5 -> state becomes RELEASE with level still 5; the next tick gives 4.
